// File: rtl/uart_rx_oversampled.sv
// ----------------------------------------------------------------------------
// uart_rx_oversampled
//
// Purpose:
//   Serial UART receiver. Each clk cycle is one oversample tick; a bit lasts
//   OVERSAMPLE ticks. Frame: start(0), DATA_BITS data bits LSB first, optional
//   parity bit, two stop bits(1), line idles high. Each received frame is
//   presented as a one-cycle dv pulse together with the byte and its
//   parity/frame error flags; those outputs then hold until the next dv.
//
// Ports:
//   clk            in   1          system clock, OVERSAMPLE x bit rate
//   rst            in   1          synchronous, active-high reset
//   in             in   1          asynchronous serial line, idle high
//   parity_config  in   2          [1]=parity present, [0]=1 odd / 0 even;
//                                  captured when a start edge is detected
//   data           out  DATA_BITS  last received byte, held until next dv
//   dv             out  1          one-cycle pulse, data/flags valid
//   parity_error   out  1          parity mismatch on last frame
//   frame_error    out  1          a stop bit was sampled low on last frame
//   busy           out  1          receiver is not idle
//   state_dbg      out  3          current receiver state (debug observation)
//
// Handshake: dv is a pure strobe with no back-pressure. The byte and flags
// are guaranteed stable in the dv cycle and in every cycle after it until
// the next dv pulse; a consumer that misses the pulse still sees the value.
// ----------------------------------------------------------------------------
module uart_rx_oversampled #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in,
    input  logic [1:0]           parity_config,
    output logic [DATA_BITS-1:0] data,
    output logic                 dv,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 busy,
    output logic [2:0]           state_dbg
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    // Start bit is confirmed half a bit after the edge; from then on every
    // full bit period lands in the middle of the next bit.
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 armed_q, armed_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [1:0]           cfg_q, cfg_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop_bad_q, stop_bad_d;
    logic                 par_bad_q, par_bad_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 dv_q, dv_d;
    logic                 parity_error_q, parity_error_d;
    logic                 frame_error_q, frame_error_d;
    logic                 busy_q, busy_d;

    logic s_in;
    logic tick_last;

    assign s_in      = sync2_q;
    assign tick_last = (tick_q == TICK_LAST);

    always_comb begin
        sync1_d        = in;
        sync2_d        = sync1_q;
        state_d        = state_q;
        armed_d        = armed_q;
        tick_d         = tick_q;
        bit_d          = bit_q;
        cfg_d          = cfg_q;
        shift_d        = shift_q;
        stop_bad_d     = stop_bad_q;
        par_bad_d      = par_bad_q;
        data_d         = data_q;
        dv_d           = 1'b0;
        parity_error_d = parity_error_q;
        frame_error_d  = frame_error_q;

        unique case (state_q)
            ST_IDLE: begin
                // Only a high-to-low transition counts as a start edge, so a
                // line stuck low after a break cannot spawn another frame.
                if (s_in) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !s_in) begin
                    state_d = ST_START;
                    armed_d = 1'b0;
                    tick_d  = '0;
                    cfg_d   = parity_config;
                end
            end

            ST_START: begin
                tick_d = tick_q + TW'(1);
                if (tick_q == TICK_MID) begin
                    tick_d = '0;
                    if (s_in) begin
                        state_d = ST_IDLE;  // glitch: too short to be a start bit
                    end else begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                    end
                end
            end

            ST_DATA: begin
                tick_d = tick_last ? '0 : tick_q + TW'(1);
                if (tick_last) begin
                    shift_d = {s_in, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BIT_LAST) begin
                        state_d    = cfg_q[1] ? ST_PARITY : ST_STOP1;
                        stop_bad_d = 1'b0;
                        par_bad_d  = 1'b0;
                    end
                end
            end

            ST_PARITY: begin
                tick_d = tick_last ? '0 : tick_q + TW'(1);
                if (tick_last) begin
                    // XOR over data and parity bit must equal 1 for odd, 0 for even.
                    par_bad_d = ((^shift_q) ^ s_in) != cfg_q[0];
                    state_d   = ST_STOP1;
                end
            end

            ST_STOP1: begin
                tick_d = tick_last ? '0 : tick_q + TW'(1);
                if (tick_last) begin
                    stop_bad_d = !s_in;
                    state_d    = ST_STOP2;
                end
            end

            ST_STOP2: begin
                tick_d = tick_last ? '0 : tick_q + TW'(1);
                if (tick_last) begin
                    dv_d           = 1'b1;
                    data_d         = shift_q;
                    parity_error_d = par_bad_q;
                    frame_error_d  = stop_bad_q | !s_in;
                    state_d        = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            state_q        <= ST_IDLE;
            armed_q        <= 1'b0;
            tick_q         <= '0;
            bit_q          <= '0;
            cfg_q          <= '0;
            shift_q        <= '0;
            stop_bad_q     <= 1'b0;
            par_bad_q      <= 1'b0;
            data_q         <= '0;
            dv_q           <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            state_q        <= state_d;
            armed_q        <= armed_d;
            tick_q         <= tick_d;
            bit_q          <= bit_d;
            cfg_q          <= cfg_d;
            shift_q        <= shift_d;
            stop_bad_q     <= stop_bad_d;
            par_bad_q      <= par_bad_d;
            data_q         <= data_d;
            dv_q           <= dv_d;
            parity_error_q <= parity_error_d;
            frame_error_q  <= frame_error_d;
            busy_q         <= busy_d;
        end
    end

    assign data         = data_q;
    assign dv           = dv_q;
    assign parity_error = parity_error_q;
    assign frame_error  = frame_error_q;
    assign busy         = busy_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_oversampled
//
// Drives directed UART frames bit by bit and predicts, per frame, the cycle
// at which dv must pulse plus the byte and flags it must carry. A single
// compare process checks every cycle: dv exactly on predicted cycles, and
// data/flags holding their last predicted values everywhere else.
// ----------------------------------------------------------------------------
module tb_uart_rx_oversampled;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in  = 1'b1;
    logic [1:0] parity_config = 2'b00;
    logic [7:0] data;
    logic       dv;
    logic       parity_error;
    logic       frame_error;
    logic       busy;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_oversampled #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .in            (in),
        .parity_config (parity_config),
        .data          (data),
        .dv            (dv),
        .parity_error  (parity_error),
        .frame_error   (frame_error),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    // ---------------- scoreboard ----------------
    // entry = {due cycle[31:0], data[7:0], parity_error, frame_error}
    logic [41:0] exp_q[$];
    logic [7:0]  m_data = 8'h00;
    logic        m_pe   = 1'b0;
    logic        m_fe   = 1'b0;
    int          total  = 0;
    int          bad    = 0;
    bit          chk_en = 1'b0;

    int          last_dv_cyc = -1;
    int          dv_count    = 0;
    logic [7:0]  cap_data;
    logic        cap_pe;
    logic        cap_fe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [41:0] e;
        if (rst) begin
            exp_q.delete();
            m_data = 8'h00;
            m_pe   = 1'b0;
            m_fe   = 1'b0;
        end else if (chk_en) begin
            if (exp_q.size() > 0 && int'(exp_q[0][41:10]) == cyc) begin
                e = exp_q.pop_front();
                check("dv_pulse", 32'(dv), 32'd1);
                check("dv_data", 32'(data), 32'(e[9:2]));
                check("dv_parity_error", 32'(parity_error), 32'(e[1]));
                check("dv_frame_error", 32'(frame_error), 32'(e[0]));
                m_data = e[9:2];
                m_pe   = e[1];
                m_fe   = e[0];
            end else begin
                check("dv_quiet", 32'(dv), 32'd0);
                check("hold", 32'({data, parity_error, frame_error}), 32'({m_data, m_pe, m_fe}));
            end
            if (dv) begin
                last_dv_cyc = cyc;
                dv_count++;
                cap_data = data;
                cap_pe   = parity_error;
                cap_fe   = frame_error;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Sends start, 8 data bits LSB first, parity (if cfg[1]), stop1, stop2.
    // Only the first nbits bit periods are driven; a truncated frame is not
    // expected to produce dv. cfg_mid is applied on the line after the start
    // bit to show that changes mid-frame are ignored.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] cfg, input logic p,
                              input logic s1, input logic s2, input int nbits,
                              input logic [1:0] cfg_mid, output int c);
        logic seq[12];
        int   n;
        int   ones;
        logic pe_e;
        logic fe_e;
        int   due;
        parity_config = cfg;
        @(negedge clk);
        c = cyc;
        n = cfg[1] ? 12 : 11;
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[1 + i] = d[i];
        if (cfg[1]) begin
            seq[9] = p; seq[10] = s1; seq[11] = s2;
        end else begin
            seq[9] = s1; seq[10] = s2; seq[11] = 1'b1;
        end
        ones = $countones({d, p});
        pe_e = cfg[1] ? (cfg[0] ? (ones % 2 == 0) : (ones % 2 == 1)) : 1'b0;
        fe_e = !(s1 && s2);
        // First edge seeing the line low is c+1; dv follows 2 sync + 7 start
        // + 16 per remaining bit + 1 register cycles later.
        due = c + 1 + 10 + 16 * (n - 1);
        if (nbits >= n) exp_q.push_back({32'(due), d, pe_e, fe_e});
        for (int k = 0; k < n && k < nbits; k++) begin
            in = seq[k];
            if (k == 1) parity_config = cfg_mid;
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int c;
    int cnt_before;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data), 32'h0);
        check("rst_dv", 32'(dv), 32'h0);
        check("rst_flags", 32'({parity_error, frame_error}), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;
        idle(10);

        // 1: no parity, 0xA5
        send_frame(8'hA5, 2'b00, 1'b0, 1'b1, 1'b1, 99, 2'b00, c);
        idle(20);
        check("t1_latency", 32'(last_dv_cyc - c - 1), 32'd170);
        check("t1_data", 32'(cap_data), 32'hA5);
        check("t1_busy_idle", 32'(busy), 32'h0);

        // 2: even parity, good then bad parity bit, back to back
        send_frame(8'h3C, 2'b10, 1'b0, 1'b1, 1'b1, 99, 2'b10, c);
        send_frame(8'h3C, 2'b10, 1'b1, 1'b1, 1'b1, 99, 2'b10, c);
        idle(20);
        check("t2_pe", 32'(cap_pe), 32'h1);
        check("t2_data", 32'(cap_data), 32'h3C);

        // 3: odd parity, config scrambled mid-frame
        send_frame(8'h01, 2'b11, 1'b0, 1'b1, 1'b1, 99, 2'b00, c);
        idle(20);
        check("t3_latency", 32'(last_dv_cyc - c - 1), 32'd186);
        check("t3_pe", 32'(cap_pe), 32'h0);

        // 4: bad second stop bit, then a good frame clears the flag
        send_frame(8'h55, 2'b00, 1'b0, 1'b1, 1'b0, 99, 2'b00, c);
        idle(20);
        check("t4_fe", 32'(cap_fe), 32'h1);
        check("t4_data", 32'(cap_data), 32'h55);
        send_frame(8'hC3, 2'b00, 1'b0, 1'b1, 1'b1, 99, 2'b00, c);
        idle(20);
        check("t4_fe_clear", 32'(cap_fe), 32'h0);

        // 5: 4-cycle glitch
        cnt_before = dv_count;
        @(negedge clk);
        c = cyc;
        in = 1'b0;
        repeat (4) @(negedge clk);
        in = 1'b1;
        @(negedge clk);
        check("t5_busy_high", 32'(busy), 32'h1);
        repeat (8) @(negedge clk);
        check("t5_busy_low", 32'(busy), 32'h0);
        idle(20);
        check("t5_no_dv", 32'(dv_count), 32'(cnt_before));

        // break: line low for a whole frame and beyond
        cnt_before = dv_count;
        send_frame(8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 99, 2'b00, c);
        repeat (80) @(negedge clk);
        idle(30);
        check("brk_one_dv", 32'(dv_count), 32'(cnt_before + 1));
        check("brk_fe", 32'(cap_fe), 32'h1);

        // 6: reset during data bit 3 of 0xFF, then 0x81
        send_frame(8'hFF, 2'b00, 1'b0, 1'b1, 1'b1, 4, 2'b00, c);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_busy_rst", 32'(busy), 32'h0);
        rst = 1'b0;
        cnt_before = dv_count;
        idle(48);
        send_frame(8'h81, 2'b00, 1'b0, 1'b1, 1'b1, 99, 2'b00, c);
        idle(20);
        check("t6_one_dv", 32'(dv_count), 32'(cnt_before + 1));
        check("t6_data", 32'(cap_data), 32'h81);
        check("t6_flags", 32'({cap_pe, cap_fe}), 32'h0);

        check("pending", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
